mod_symbol_ctrl: RTL and testbench

MOD_SYMBOL_CTRL -- requirements
Module: mod_symbol_ctrl

---
 rtl/mod_symbol_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mod_symbol_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mod_symbol_ctrl.sv
// ---------------------------------------------------------------------------
// mod_symbol_ctrl
//
// Serialises a DATA_W-bit word into modulation symbols, MSB first. Each
// symbol lasts SYM_CYCLES clocks. At the start of every symbol the block
// pulses 'load' and presents the divider code {msb,cnt} for the carrier
// divider. It also drives 'carrier_en' to gate the output mixer.
//   ASK (mode=0): code = div_hi, and the carrier is gated by the bit value.
//   FSK (mode=1): code = bit ? div_hi : div_lo, and the carrier is always on.
//
// Optional feature (macro MOD_PARITY_EN): after bit 0, one extra PARITY
// symbol is sent. It carries the even parity (XOR) of the word and is coded
// like a data bit.
//
// Handshake: a word is accepted on a rising clk edge where in_valid and
// in_ready are both 1. in_ready is 1 only in IDLE. in_valid is ignored in
// every other state, and the inputs are sampled only at the acceptance edge.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   [DATA_W-1:0] word to transmit
//   in_valid   in   in_data valid
//   in_ready   out  block can accept a word (IDLE)
//   mode       in   0 = ASK, 1 = FSK
//   div_hi     in   [3:0] {msb,cnt} code for bit value 1
//   div_lo     in   [3:0] {msb,cnt} code for bit value 0 (FSK only)
//   load       out  one-cycle pulse in the first cycle of every symbol
//   msb, cnt   out  divider code for the current symbol
//   carrier_en out  carrier gate
//   busy       out  word in flight
//   done       out  one-cycle pulse in the first IDLE cycle after a word
//   dbg_state  out  [1:0] current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module mod_symbol_ctrl #(
  parameter int SYM_CYCLES = 4096,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [3:0]        div_hi,
  input  logic [3:0]        div_lo,
  output logic              load,
  output logic              msb,
  output logic [2:0]        cnt,
  output logic              carrier_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int          IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0] CNT_RELOAD = 16'(SYM_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);

`ifdef MOD_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SYMBOL = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SYMBOL = 2'd1} state_t;
`endif

  state_t             state_q,   state_d;
  logic [15:0]        sym_cnt_q, sym_cnt_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  data_q,    data_d;
  logic               mode_q,    mode_d;
  logic [3:0]         hi_q,      hi_d;
  logic [3:0]         lo_q,      lo_d;
  logic               load_q,    load_d;
  logic [3:0]         code_q,    code_d;
  logic               car_q,     car_d;
  logic               done_q,    done_d;
  logic [IDX_W-1:0]   nxt_idx;

  // Code 0 is not a legal divider base, so it is promoted to 1 on latch.
  function automatic logic [3:0] fix_code(input logic [3:0] c);
    return (c == 4'd0) ? 4'd1 : c;
  endfunction

  // ASK always uses div_hi. FSK selects the code by the bit value.
  function automatic logic [3:0] sym_code(input logic m, input logic b,
                                          input logic [3:0] hi,
                                          input logic [3:0] lo);
    return (m && !b) ? lo : hi;
  endfunction

  assign nxt_idx = bit_idx_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    mode_d    = mode_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    load_d    = 1'b0;
    code_d    = code_q;
    car_d     = car_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        code_d = 4'd0;
        car_d  = 1'b0;
        if (in_valid) begin
          data_d    = in_data;
          mode_d    = mode;
          hi_d      = fix_code(div_hi);
          lo_d      = fix_code(div_lo);
          state_d   = SYMBOL;
          bit_idx_d = IDX_MSB;
          sym_cnt_d = CNT_RELOAD;
          load_d    = 1'b1;
          // The first symbol is computed from the raw inputs, because the
          // latched copies only become visible one cycle later.
          code_d    = sym_code(mode, in_data[DATA_W-1],
                               fix_code(div_hi), fix_code(div_lo));
          car_d     = mode | in_data[DATA_W-1];
        end
      end

      SYMBOL: begin
        if (sym_cnt_q != 16'd0) begin
          sym_cnt_d = sym_cnt_q - 16'd1;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = nxt_idx;
          sym_cnt_d = CNT_RELOAD;
          load_d    = 1'b1;
          code_d    = sym_code(mode_q, data_q[nxt_idx], hi_q, lo_q);
          car_d     = mode_q | data_q[nxt_idx];
        end else begin
`ifdef MOD_PARITY_EN
          state_d   = PARITY;
          sym_cnt_d = CNT_RELOAD;
          load_d    = 1'b1;
          code_d    = sym_code(mode_q, ^data_q, hi_q, lo_q);
          car_d     = mode_q | (^data_q);
`else
          state_d   = IDLE;
          done_d    = 1'b1;
          code_d    = 4'd0;
          car_d     = 1'b0;
`endif
        end
      end

`ifdef MOD_PARITY_EN
      PARITY: begin
        if (sym_cnt_q != 16'd0) begin
          sym_cnt_d = sym_cnt_q - 16'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          code_d  = 4'd0;
          car_d   = 1'b0;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        code_d  = 4'd0;
        car_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sym_cnt_q <= 16'd0;
      bit_idx_q <= '0;
      data_q    <= '0;
      mode_q    <= 1'b0;
      hi_q      <= 4'd0;
      lo_q      <= 4'd0;
      load_q    <= 1'b0;
      code_q    <= 4'd0;
      car_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      load_q    <= load_d;
      code_q    <= code_d;
      car_q     <= car_d;
      done_q    <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign load       = load_q;
  assign msb        = code_q[3];
  assign cnt        = code_q[2:0];
  assign carrier_en = car_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mod_symbol_ctrl.sv
module tb_mod_symbol_ctrl;
  localparam int SYM = 8;
  localparam int DW  = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [3:0]    div_hi;
  logic [3:0]    div_lo;
  logic          load;
  logic          msb;
  logic [2:0]    cnt;
  logic          carrier_en;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  mod_symbol_ctrl #(.SYM_CYCLES(SYM), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .load       (load),
    .msb        (msb),
    .cnt        (cnt),
    .carrier_en (carrier_en),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    in_data = DW'($urandom);
    mode    = 1'($urandom_range(0, 1));
    div_hi  = 4'($urandom_range(0, 15));
    div_lo  = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".load"},     32'(load),     32'd0);
    chk({tag, ".code"},     32'({msb, cnt}), 32'd0);
    chk({tag, ".carrier"},  32'(carrier_en), 32'd0);
    chk({tag, ".done"},     32'(done),     32'(exp_done));
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      scramble_inputs();
      tick();
      chk_idle("idle", 1'b0);
    end
  endtask

  // Reference model: the word becomes a list of symbol bits (MSB first, then
  // optional parity). Each bit lasts SYM cycles with a load only in its first
  // cycle. done is expected in the cycle right after the last symbol.
  // If abort_at > 0, rst is raised in that symbol cycle (1-based).
  task automatic run_word(input logic [DW-1:0] d, input logic m,
                          input logic [3:0] hi, input logic [3:0] lo,
                          input int abort_at);
    logic       bits[$];
    logic [3:0] hi_f;
    logic [3:0] lo_f;
    logic [3:0] exp_code;
    logic       exp_car;
    int         k;
    int         total;
    hi_f = (hi == 4'd0) ? 4'd1 : hi;
    lo_f = (lo == 4'd0) ? 4'd1 : lo;
    for (int i = DW - 1; i >= 0; i--) bits.push_back(d[i]);
`ifdef MOD_PARITY_EN
    bits.push_back(^d);
`endif
    total = bits.size() * SYM;
    in_data  = d;
    mode     = m;
    div_hi   = hi;
    div_lo   = lo;
    in_valid = 1'b1;
    tick();
    k = 0;
    foreach (bits[s]) begin
      exp_code = (m && !bits[s]) ? lo_f : hi_f;
      exp_car  = m | bits[s];
      for (int c = 0; c < SYM; c++) begin
        k++;
        if (k == abort_at) begin
          rst = 1'b1;
          #1;
          chk_idle("rst_async", 1'b0);
          in_valid = 1'b0;
          tick();
          chk_idle("rst_held", 1'b0);
          #2;
          rst = 1'b0;
          return;
        end
        chk("sym.load",     32'(load),       32'(c == 0));
        chk("sym.code",     32'({msb, cnt}), 32'(exp_code));
        chk("sym.carrier",  32'(carrier_en), 32'(exp_car));
        chk("sym.busy",     32'(busy),       32'd1);
        chk("sym.in_ready", 32'(in_ready),   32'd0);
        chk("sym.done",     32'(done),       32'd0);
        // Inputs must be ignored while a word is in flight.
        scramble_inputs();
        in_valid = (k == total) ? 1'b0 : 1'($urandom_range(0, 1));
        tick();
      end
    end
    chk("latency", 32'(k), 32'(total));
    chk_idle("done_cycle", 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    mode     = 1'b0;
    div_hi   = 4'd0;
    div_lo   = 4'd0;
    #12;
    chk_idle("reset", 1'b0);
    #1;
    rst = 1'b0;

    // Accept on the first edge after reset release: FSK A5, codes 6,3,...
    run_word(8'hA5, 1'b1, 4'h6, 4'h3, 0);
    idle_cycles(2);

    // ASK F0: carrier high 32 cycles, then low 32, code 4 throughout
    run_word(8'hF0, 1'b0, 4'h4, 4'h9, 0);

    // Back-to-back: the next word is accepted in the done cycle
    run_word(8'h3C, 1'b1, 4'hA, 4'h2, 0);
    run_word(8'h07, 1'b1, 4'h5, 4'h0, 0);   // div_lo=0 promoted to 1
    idle_cycles(1);

    // ASK with div_hi=0 promoted to 1
    run_word(8'h81, 1'b0, 4'h0, 4'h0, 0);

    // Reset in cycle 20 of a word, then a normal word right after release
    run_word(8'h5A, 1'b1, 4'h7, 4'h2, 20);
    run_word(8'hC3, 1'b1, 4'hE, 4'h1, 0);

    // Randomized words with random gaps (0 = back-to-back)
    for (int w = 0; w < 12; w++) begin
      run_word(DW'($urandom), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
